// File: rtl/ysyx_22050078_lsu_mem_ctrl.sv
// LSU memory controller: one outstanding load/store on a req/gnt/rvalid bus.
// Aligns stores into byte lanes and formats load results.
module ysyx_22050078_lsu_mem_ctrl #(
  parameter int CPU_WIDTH = 64,
  parameter int MASKW     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lsu_valid,
  input  logic [CPU_WIDTH-1:0] i_lsu_exres,
  input  logic [CPU_WIDTH-1:0] i_lsu_sdata,
  input  logic                 i_lsu_lden,
  input  logic                 i_lsu_sten,
  input  logic [2:0]           i_lsu_func,
  output logic [CPU_WIDTH-1:0] o_lsu_lsres,
  output logic                 o_lsu_stall,
  output logic                 o_lsu_err,
  output logic                 o_mem_req,
  output logic                 o_mem_wen,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [MASKW-1:0]     o_mem_wmask,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t               state;
  logic [CPU_WIDTH-1:0] addr_q;
  logic [2:0]           off_q;
  logic [2:0]           func_q;
  logic                 wen_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [MASKW-1:0]     wmask_q;
  logic [CPU_WIDTH-1:0] res_q;

  logic [2:0]           off;
  logic                 aligned;
  logic                 legal;
  logic                 single;
  logic                 is_idle;
  logic                 start;
  logic [MASKW-1:0]     bmask;
  logic [MASKW-1:0]     smask;
  logic [CPU_WIDTH-1:0] sdat;
  logic [CPU_WIDTH-1:0] lane;
  logic [CPU_WIDTH-1:0] fmt;

  assign off = i_lsu_exres[2:0];

  always_comb begin
    aligned = 1'b1;
    bmask   = MASKW'(8'h01);
    unique case (i_lsu_func[1:0])
      2'd0: begin
        aligned = 1'b1;
        bmask   = MASKW'(8'h01);
      end
      2'd1: begin
        aligned = ~off[0];
        bmask   = MASKW'(8'h03);
      end
      2'd2: begin
        aligned = (off[1:0] == 2'b00);
        bmask   = MASKW'(8'h0F);
      end
      default: begin
        aligned = (off == 3'b000);
        bmask   = MASKW'(8'hFF);
      end
    endcase
  end

  assign legal   = i_lsu_lden ? (i_lsu_func != 3'd7)
                              : ~i_lsu_func[2];
  assign single  = i_lsu_lden ^ i_lsu_sten;
  assign is_idle = (state == IDLE);
  assign start   = is_idle & i_lsu_valid & single
                 & aligned & legal;

  assign o_lsu_err = is_idle & i_lsu_valid
                   & ((i_lsu_lden & i_lsu_sten)
                   | (single & ~(aligned & legal)));

  assign smask = bmask << off;
  assign sdat  = i_lsu_sdata << {off, 3'b000};

  // load formatting works on the latched offset/func only
  assign lane = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    fmt = '0;
    unique case (func_q)
      3'd0: fmt = {{(CPU_WIDTH-8){lane[7]}}, lane[7:0]};
      3'd1: fmt = {{(CPU_WIDTH-16){lane[15]}}, lane[15:0]};
      3'd2: fmt = {{(CPU_WIDTH-32){lane[31]}}, lane[31:0]};
      3'd3: fmt = lane;
      3'd4: fmt = {{(CPU_WIDTH-8){1'b0}}, lane[7:0]};
      3'd5: fmt = {{(CPU_WIDTH-16){1'b0}}, lane[15:0]};
      3'd6: fmt = {{(CPU_WIDTH-32){1'b0}}, lane[31:0]};
      default: fmt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      func_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      res_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            addr_q  <= {i_lsu_exres[CPU_WIDTH-1:3], 3'b000};
            off_q   <= off;
            func_q  <= i_lsu_func;
            wen_q   <= i_lsu_sten;
            wdata_q <= i_lsu_sten ? sdat : '0;
            wmask_q <= i_lsu_sten ? smask : '0;
          end
        end
        REQ: begin
          if (i_mem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            state <= DONE;
            res_q <= wen_q ? '0 : fmt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_req   = (state == REQ);
  assign o_mem_wen   = o_mem_req & wen_q;
  assign o_mem_addr  = o_mem_req ? addr_q : '0;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;
  assign o_mem_wmask = o_mem_req ? wmask_q : '0;
  assign o_lsu_stall = start | o_mem_req | (state == WAIT);
  assign o_lsu_lsres = (state == DONE) ? res_q : '0;

endmodule

// File: tb/tb_ysyx_22050078_lsu_mem_ctrl.sv
// Bench for ysyx_22050078_lsu_mem_ctrl: directed cases plus randomized
// accesses against a byte-lane arithmetic reference model.
module tb_ysyx_22050078_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [63:0] exres;
  logic [63:0] sdata;
  logic        lden;
  logic        sten;
  logic [2:0]  func;
  logic [63:0] lsres;
  logic        stall;
  logic        err;
  logic        mreq;
  logic        mwen;
  logic [63:0] maddr;
  logic [63:0] mwdata;
  logic [7:0]  mwmask;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  int checks;
  int failures;

  ysyx_22050078_lsu_mem_ctrl #(
    .CPU_WIDTH(64),
    .MASKW(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_lsu_valid(valid),
    .i_lsu_exres(exres),
    .i_lsu_sdata(sdata),
    .i_lsu_lden(lden),
    .i_lsu_sten(sten),
    .i_lsu_func(func),
    .o_lsu_lsres(lsres),
    .o_lsu_stall(stall),
    .o_lsu_err(err),
    .o_mem_req(mreq),
    .o_mem_wen(mwen),
    .o_mem_addr(maddr),
    .o_mem_wdata(mwdata),
    .o_mem_wmask(mwmask),
    .i_mem_gnt(gnt),
    .i_mem_rvalid(rvalid),
    .i_mem_rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int size_of(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic m_err(logic v, logic l, logic s,
                                 logic [2:0] f, logic [63:0] a);
    if (!v) return 1'b0;
    if (l && s) return 1'b1;
    if (!l && !s) return 1'b0;
    if (l && f == 3'd7) return 1'b1;
    if (s && f >= 3'd4) return 1'b1;
    return (a % 64'(size_of(f))) != 0;
  endfunction

  function automatic logic [7:0] m_mask(logic s, logic [2:0] f,
                                        logic [63:0] a);
    int m;
    if (!s) return 8'h00;
    m = ((1 << size_of(f)) - 1) << int'(a % 8);
    return 8'(m);
  endfunction

  function automatic logic [63:0] m_load(logic [2:0] f, logic [63:0] a,
                                         logic [63:0] d);
    longint unsigned v;
    longint unsigned lim;
    int n;
    n = size_of(f);
    v = d >> (8 * int'(a % 8));
    if (n < 8) begin
      lim = 64'd1 << (8 * n);
      v = v % lim;
      if (f < 3'd4 && v >= lim / 2) v = v + ~(lim - 1);
    end
    return v;
  endfunction

  task automatic idle_inputs();
    valid = 0; lden = 0; sten = 0; func = 0;
    exres = 0; sdata = 0; gnt = 0; rvalid = 0; rdata = 0;
  endtask

  // one instruction from its IDLE cycle through DONE
  task automatic run_op(string nm, logic v, logic l, logic s,
                        logic [2:0] f, logic [63:0] a,
                        logic [63:0] sd, logic [63:0] rd,
                        int gdly, int rdly);
    logic        e_err;
    logic        mem;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    logic [7:0]  e_wm;
    logic [63:0] e_res;
    int          nstall;
    @(negedge clk);
    valid = v; lden = l; sten = s; func = f;
    exres = a; sdata = sd; gnt = 0; rvalid = 0; rdata = 0;
    e_err  = m_err(v, l, s, f, a);
    mem    = v && (l ^ s) && !e_err;
    e_addr = a & ~64'h7;
    e_wd   = s ? sd << (8 * int'(a % 8)) : 64'h0;
    e_wm   = m_mask(s, f, a);
    e_res  = s ? 64'h0 : m_load(f, a, rd);
    nstall = 0;
    #1;
    checks++;
    if (err !== e_err || stall !== mem || mreq !== 1'b0
        || lsres !== 64'h0) begin
      failures++;
      $display("FAIL %s issue: err=%b stall=%b req=%b lsres=%h want err=%b stall=%b req=0 lsres=0",
               nm, err, stall, mreq, lsres, e_err, mem);
    end
    if (stall) nstall++;
    if (!mem) return;
    for (int k = 0; k <= gdly; k++) begin
      @(negedge clk);
      valid = 1'($urandom); exres = {$urandom, $urandom};
      sdata = {$urandom, $urandom}; func = 3'($urandom);
      lden = 1'($urandom); sten = 1'($urandom);
      gnt = (k == gdly); rvalid = 1'($urandom);
      #1;
      checks++;
      if (mreq !== 1'b1 || mwen !== s || maddr !== e_addr
          || mwdata !== e_wd || mwmask !== e_wm || stall !== 1'b1
          || err !== 1'b0) begin
        failures++;
        $display("FAIL %s req%0d: req=%b wen=%b addr=%h wd=%h wm=%h st=%b err=%b want 1 %b %h %h %h 1 0",
                 nm, k, mreq, mwen, maddr, mwdata, mwmask, stall, err,
                 s, e_addr, e_wd, e_wm);
      end
      if (stall) nstall++;
    end
    for (int k = 0; k <= rdly; k++) begin
      @(negedge clk);
      gnt = 1'($urandom); rvalid = (k == rdly);
      exres = {$urandom, $urandom}; func = 3'($urandom);
      rdata = (k == rdly) ? rd : {$urandom, $urandom};
      #1;
      checks++;
      if (mreq !== 1'b0 || mwen !== 1'b0 || mwmask !== 8'h0
          || stall !== 1'b1 || lsres !== 64'h0) begin
        failures++;
        $display("FAIL %s wait%0d: req=%b wen=%b wm=%h st=%b lsres=%h want 0 0 0 1 0",
                 nm, k, mreq, mwen, mwmask, stall, lsres);
      end
      if (stall) nstall++;
    end
    @(negedge clk);
    idle_inputs();
    rdata = {$urandom, $urandom};
    #1;
    checks++;
    if (lsres !== e_res || stall !== 1'b0 || mreq !== 1'b0) begin
      failures++;
      $display("FAIL %s done: lsres=%h st=%b req=%b want lsres=%h st=0 req=0",
               nm, lsres, stall, mreq, e_res);
    end
    checks++;
    if (nstall !== gdly + rdly + 3) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d want %0d",
               nm, nstall, gdly + rdly + 3);
    end
  endtask

  task automatic check_quiet(string nm);
    checks++;
    if (mreq !== 0 || mwen !== 0 || maddr !== 0 || mwdata !== 0
        || mwmask !== 0 || lsres !== 0 || stall !== 0 || err !== 0) begin
      failures++;
      $display("FAIL %s: req=%b wen=%b addr=%h wd=%h wm=%h lsres=%h st=%b err=%b want all 0",
               nm, mreq, mwen, maddr, mwdata, mwmask, lsres, stall, err);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    check_quiet("reset_hold");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    check_quiet("reset_release");
  endtask

  task automatic test_directed();
    run_op("lb_neg", 1, 1, 0, 3'd0, 64'h8000_0003, 64'h0,
           64'h0000_0000_8000_0000, 0, 0);
    run_op("sh_hi", 1, 0, 1, 3'd1, 64'h1006, 64'h1234, 64'h0, 0, 0);
    run_op("lw_misal", 1, 1, 0, 3'd2, 64'h1002, 64'h0, 64'h0, 0, 0);
    run_op("ld_slow", 1, 1, 0, 3'd3, 64'h3000, 64'h0,
           64'h0123_4567_89AB_CDEF, 4, 1);
    run_op("ld_f7", 1, 1, 0, 3'd7, 64'h3000, 64'h0, 64'h0, 0, 0);
    run_op("st_f4", 1, 0, 1, 3'd4, 64'h3000, 64'h0, 64'h0, 0, 0);
    run_op("ld_and_st", 1, 1, 1, 3'd0, 64'h3000, 64'h0, 64'h0, 0, 0);
    run_op("sw_off4", 1, 0, 1, 3'd2, 64'h4004, 64'hAABB_CCDD,
           64'h0, 1, 2);
    run_op("lhu_off6", 1, 1, 0, 3'd5, 64'h4006, 64'h0,
           64'hF00D_0000_0000_0000, 0, 0);
    run_op("sd_full", 1, 0, 1, 3'd3, 64'h4008, 64'hDEAD_BEEF_CAFE_F00D,
           64'h0, 0, 0);
    run_op("noval_ld", 0, 1, 0, 3'd0, 64'h4001, 64'h0, 64'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid = 1; lden = 1; sten = 0; func = 3'd3; exres = 64'h5000;
    @(negedge clk);
    idle_inputs();
    gnt = 1;
    @(negedge clk);
    gnt = 0;
    #1;
    checks++;
    if (stall !== 1'b1 || mreq !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait: st=%b req=%b want st=1 req=0",
               stall, mreq);
    end
    #2 rst_n = 0;
    #1;
    check_quiet("reset_mid_async");
    @(negedge clk);
    rst_n = 1;
    rvalid = 1; rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    rvalid = 0;
    #1;
    check_quiet("reset_mid_drop1");
    @(negedge clk);
    #1;
    check_quiet("reset_mid_drop2");
  endtask

  task automatic test_back_to_back();
    run_op("add1", 1, 0, 0, 3'd0, 64'h1234, 64'h0, 64'h0, 0, 0);
    run_op("lwu_b2b", 1, 1, 0, 3'd6, 64'h2004, 64'h0,
           64'hDEAD_BEEF_0000_0000, 0, 0);
    run_op("add2", 1, 0, 0, 3'd0, 64'h5678, 64'h0, 64'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic        l;
      logic        s;
      logic [63:0] a;
      int          sel;
      f   = 3'($urandom);
      sel = $urandom_range(0, 9);
      l   = (sel < 5) || (sel == 9);
      s   = (sel >= 5);
      if (sel == 8) begin
        l = 0; s = 0;
      end
      a = {32'h0, $urandom};
      if ($urandom_range(0, 3) != 0)
        a = a & ~64'(size_of(f) - 1);
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 7) != 0),
             l, s, f, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
